instr_field_queue: RTL and testbench
====================================

INSTR_FIELD_QUEUE -- requirements
Module: instr_field_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries; DEPTH SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter PC_W, default 32, giving the width of the stored program-counter tag.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, width 1: the single clock, rising-edge active.
REQ-005 Port reset, input, width 1: asynchronous, active-low reset.
REQ-006 Port flush, input, width 1: synchronous discard of all entries.
REQ-007 Port in_valid, input, width 1: the producer offers an instruction.
REQ-008 Port in_ready, output, width 1: the queue can accept an instruction.
REQ-009 Port in_instr, input, width 32: the MIPS instruction word.
REQ-010 Port in_pc, input, width PC_W: the PC of the instruction.
REQ-011 Port out_valid, output, width 1: the head entry is valid.
REQ-012 Port out_ready, input, width 1: the consumer takes the head entry.
REQ-013 Port out_instr, output, width 32; port out_pc, output, width PC_W: the head entry's instruction and PC.
REQ-014 The head entry's fields SHALL be output as follows:
- Opcode, width 6: bits [31:26]
- Rs, width 5: bits [25:21]
- Rt, width 5: bits [20:16]
- Rd, width 5: bits [15:11]
- Shamt, width 5: bits [10:6]
- Func, width 6: bits [5:0]
- Imme16, width 16: bits [15:0]
- Imme26, width 26: bits [25:0]
REQ-015 Port ext_op, input, width 2: selects the Imme32 extension mode.
REQ-016 Port Imme32, output, width 32: the extended Imme16.
REQ-017 Port count, output, width log2(DEPTH)+1: the current number of entries.

Function
REQ-018 The queue SHALL be a circular buffer of DEPTH entries, each holding {instr, pc}, addressed by a write pointer and a read pointer, each log2(DEPTH) bits wide, wrapping modulo DEPTH.
REQ-019 A push SHALL occur on a rising clk edge when in_valid=1, in_ready=1 and flush=0: the entry is written at the write pointer, and the write pointer and count are incremented.
REQ-020 A pop SHALL occur on a rising clk edge when out_valid=1, out_ready=1 and flush=0: the read pointer is incremented and count is decremented.
REQ-021 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 in_ready SHALL be 1 exactly when count is less than DEPTH; a full queue SHALL NOT accept a push, even when a pop occurs on the same cycle.
REQ-023 out_valid SHALL be 1 exactly when count is not 0.
REQ-024 All head outputs (out_instr, out_pc, the fields and Imme32) SHALL be combinational from the entry at the read pointer; when out_valid=0 they SHALL all be 0.
REQ-025 A newly pushed entry SHALL become visible at the head one cycle after the push edge; there SHALL be no input-to-output bypass.
REQ-026 Imme32 SHALL be computed from ext_op as follows:
- 00: zero-extend Imme16
- 01: sign-extend Imme16
- 10: {Imme16, 16'h0000} (lui form)
- 11: {{14{Imme16[15]}}, Imme16, 2'b00} (branch offset)
REQ-027 flush=1 on a rising edge SHALL set both pointers and count to 0, and SHALL override any simultaneous push or pop; the entry offered on that cycle is dropped.
REQ-028 An out_ready=1 while the queue is empty, or an in_valid=1 while it is full, SHALL have no effect on state.
REQ-029 Pop-then-push sequences SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-030 While reset=0, regardless of clk: pointers=0, count=0, out_valid=0, in_ready=1, and all head outputs=0.
REQ-031 Entry storage SHALL NOT require reset; stale contents SHALL never be visible because of REQ-024.
REQ-032 Deasserting reset mid-operation SHALL yield an empty queue; entries pushed before the reset SHALL never appear at the head.

Verification
REQ-033 Reset then push 0x3C011234 (lui $1,0x1234) with ext_op=10 -> next cycle out_valid=1, Opcode=0x0F, Rt=1, Imme16=0x1234, Imme32=0x12340000, count=1.
REQ-034 Push 32'h8C22FFFC with ext_op=01 -> Opcode=0x23, Rs=1, Rt=2, Imme32=0xFFFFFFFC; then with ext_op=00 -> Imme32=0x0000FFFC; with ext_op=11 -> Imme32=0xFFFFFFF0.
REQ-035 With DEPTH=4 and out_ready=0, push 5 words -> in_ready=0 after the 4th push, count=4, the 5th word is ignored, and pops return the first 4 words in order.
REQ-036 Keep in_valid=1 and out_ready=1 continuously for 10 cycles -> after the first push, count stays 1, every word exits in order, and the pointers wrap correctly.
REQ-037 At count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the offered word is absent.
REQ-038 Assert reset (0) asynchronously between edges at count=2 -> out_valid=0 and count=0 immediately, before the next clk edge; after release, the first push reaches the head with correct fields.

Source files
------------

// File: rtl/instr_field_queue.sv
// Instruction queue: circular buffer of {instr, pc} with MIPS field decode
// and Imme32 extension on the head entry.

module ifq_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage is deliberately unreset; the head mux hides stale contents.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module instr_field_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               Opcode,
  output logic [4:0]               Rs,
  output logic [4:0]               Rt,
  output logic [4:0]               Rd,
  output logic [4:0]               Shamt,
  output logic [5:0]               Func,
  output logic [15:0]              Imme16,
  output logic [25:0]              Imme26,
  input  logic [1:0]               ext_op,
  output logic [31:0]              Imme32,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_field_queue: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  localparam int EW = $bits(entry_t);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic [DEPTH-1:0]         we;
  logic [DEPTH-1:0][EW-1:0] mem_q;
  entry_t        in_ent, head;

  assign in_ready  = cnt_q < CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  // Readiness is from the registered count, so a full queue refuses a push
  // even if a pop happens on the same edge.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_q;

  assign in_ent.instr = in_instr;
  assign in_ent.pc    = in_pc;

  always_comb begin
    we = '0;
    if (push) we[wptr_q] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    ifq_entry #(.W(EW)) u_ent (
      .clk (clk),
      .we  (we[g]),
      .d   (in_ent),
      .q   (mem_q[g])
    );
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Head is forced to zero when empty; everything below derives from it.
  assign head = out_valid ? entry_t'(mem_q[rptr_q]) : '0;

  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign Opcode    = head.instr[31:26];
  assign Rs        = head.instr[25:21];
  assign Rt        = head.instr[20:16];
  assign Rd        = head.instr[15:11];
  assign Shamt     = head.instr[10:6];
  assign Func      = head.instr[5:0];
  assign Imme16    = head.instr[15:0];
  assign Imme26    = head.instr[25:0];

  always_comb begin
    Imme32 = '0;
    case (ext_op)
      2'b00: Imme32 = {16'h0000, Imme16};
      2'b01: Imme32 = {{16{Imme16[15]}}, Imme16};
      2'b10: Imme32 = {Imme16, 16'h0000};
      2'b11: Imme32 = {{14{Imme16[15]}}, Imme16, 2'b00};
      default: Imme32 = '0;
    endcase
  end

endmodule

// File: tb/tb_instr_field_queue.sv
// Directed bench for instr_field_queue; stimulus pushes expected entries into
// a scoreboard, a negedge monitor pops and compares whenever the head is taken.

module tb_instr_field_queue;
  logic        clk = 0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, Imme32;
  logic [5:0]  Opcode, Func;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [15:0] Imme16;
  logic [25:0] Imme26;
  logic [1:0]  ext_op;
  logic [2:0]  count;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } sb_t;
  sb_t sb[$];
  int  n_chk = 0, n_fail = 0;

  instr_field_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Func(Func),
    .Imme16(Imme16), .Imme26(Imme26), .ext_op(ext_op), .Imme32(Imme32), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_underflow: got head %h expected no entry", out_instr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("head_instr", out_instr, e.instr);
        chk("head_pc", out_pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] pc, input bit acc);
    in_valid = 1; in_instr = w; in_pc = pc;
    chk("in_ready_at_push", {31'b0, in_ready}, {31'b0, acc});
    if (acc) sb.push_back('{w, pc});
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 8 && count != 0; i++) tick();
    out_ready = 0;
    chk("drain_count", count, 0);
  endtask

  initial begin
    reset = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_instr = 0; in_pc = 0; ext_op = 2'b01;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_imme32", Imme32, 0);
    tick(); tick();
    reset = 1;

    // lui $1,0x1234
    ext_op = 2'b10;
    in_valid = 1; in_instr = 32'h3C011234; in_pc = 32'h100;
    #1 chk("no_bypass", out_valid, 0);
    sb.push_back('{32'h3C011234, 32'h100});
    tick(); in_valid = 0;
    chk("lui_valid", out_valid, 1);
    chk("lui_opcode", Opcode, 6'h0F);
    chk("lui_rt", Rt, 1);
    chk("lui_imm16", Imme16, 16'h1234);
    chk("lui_imme32", Imme32, 32'h12340000);
    chk("lui_count", count, 1);
    drain();

    // lw $2,-4($1)
    push(32'h8C22FFFC, 32'h104, 1);
    ext_op = 2'b01; #1;
    chk("lw_opcode", Opcode, 6'h23);
    chk("lw_rs", Rs, 1);
    chk("lw_rt", Rt, 2);
    chk("lw_rd", Rd, 5'h1F);
    chk("lw_shamt", Shamt, 5'h1F);
    chk("lw_func", Func, 6'h3C);
    chk("lw_imme26", Imme26, 26'h022FFFC);
    chk("ext_sign", Imme32, 32'hFFFFFFFC);
    ext_op = 2'b00; #1 chk("ext_zero", Imme32, 32'h0000FFFC);
    ext_op = 2'b11; #1 chk("ext_branch", Imme32, 32'hFFFFFFF0);
    drain();

    // fill to DEPTH; 5th word offered alongside a pop must still be refused
    for (int i = 0; i < 4; i++) push(32'h1000_0000 + i, 32'h300 + 4 * i, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    out_ready = 1;
    push(32'hDEAD0005, 32'h310, 0);
    out_ready = 0;
    chk("full_pop_count", count, 3);
    drain();

    // streaming push+pop across pointer wrap
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      push(32'hA000_0000 + i, 32'h200 + 4 * i, 1);
      chk("stream_count", count, 1);
    end
    tick();
    out_ready = 0;
    chk("stream_end_count", count, 0);

    // flush at count=3 overrides push and pop
    for (int i = 0; i < 3; i++) push(32'hB000_0000 + i, 32'h400 + 4 * i, 1);
    chk("pre_flush_count", count, 3);
    flush = 1; out_ready = 1; in_valid = 1; in_instr = 32'hBADBAD00; in_pc = 32'h4FC;
    sb.delete();
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    push(32'hC0000001, 32'h500, 1);
    drain();

    // async reset mid-cycle at count=2
    push(32'hD0000000, 32'h600, 1);
    push(32'hD0000001, 32'h604, 1);
    chk("pre_rst_count", count, 2);
    #2 reset = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_instr", out_instr, 0);
    sb.delete();
    tick();
    reset = 1;
    ext_op = 2'b01;
    push(32'h2002ABCD, 32'h700, 1);
    chk("post_rst_opcode", Opcode, 6'h08);
    chk("post_rst_rs", Rs, 0);
    chk("post_rst_rt", Rt, 2);
    chk("post_rst_imme32", Imme32, 32'hFFFFABCD);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
